prog_counter: RTL and testbench
===============================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter and limit width in bits (legal range 2..32).
REQ-002 Parameter PRE_WIDTH, default 4, prescaler divisor width; used only when COUNTER_PRESCALE_EN is defined.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 load  input  1  load cnt_in into the counter.
REQ-006 enab  input  1  count enable.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 sat  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-009 cnt_in  input  WIDTH  load value.
REQ-010 limit  input  WIDTH  terminal value; the counter range is 0..limit.
REQ-011 clr_ovf  input  1  clear the sticky overflow flag.
REQ-012 prescale  input  PRE_WIDTH  divisor minus one; present only when COUNTER_PRESCALE_EN is defined.
REQ-013 cnt_out  output  WIDTH  registered count.
REQ-014 tc  output  1  registered terminal-count pulse.
REQ-015 ovf  output  1  registered sticky boundary/overflow flag.
REQ-016 at_zero  output  1  combinational; equals (cnt_out == 0).

Function
REQ-017 All state shall update only on the rising edge of clk; cnt_out changes 1 cycle after its inputs are sampled.
REQ-018 Priority shall be rst > load > step; with load=1, cnt_out <= cnt_in unclipped (even if > limit), tc <= 0, and ovf is unchanged except by clr_ovf.
REQ-019 A step shall occur when load=0, enab=1 and tick=1; tick is constant 1 when COUNTER_PRESCALE_EN is undefined.
REQ-020 Up step with cnt_out < limit: cnt_out <= cnt_out + 1, tc <= 0.
REQ-021 Up step with cnt_out >= limit (boundary): wrap mode cnt_out <= 0; saturate mode cnt_out <= limit; in both modes tc <= 1 and ovf <= 1.
REQ-022 Down step with cnt_out > 0: cnt_out <= cnt_out - 1, tc <= 0.
REQ-023 Down step with cnt_out == 0 (boundary): wrap mode cnt_out <= limit; saturate mode cnt_out holds 0; tc <= 1 and ovf <= 1.
REQ-024 Saturate mode shall raise tc on every boundary step attempt while held at the boundary.
REQ-025 tc shall be 0 in any cycle without a boundary step, so it is high for exactly one cycle per boundary step.
REQ-026 limit, up and sat shall be sampled every cycle; a change takes effect on the next step with no extra latency.
REQ-027 limit = 0: every up or down step is a boundary step, and cnt_out becomes 0 in both modes.
REQ-028 clr_ovf=1 shall clear ovf; if a boundary step occurs in the same cycle, ovf ends up 1 (set wins).
REQ-029 With enab=0 and load=0, cnt_out holds and tc <= 0.

Reset
REQ-030 With rst=1 at a clock edge: cnt_out <= 0, tc <= 0, ovf <= 0, and the prescaler divider <= 0; all other inputs are ignored.
REQ-031 Asserting rst mid-count or mid-prescale shall abort the operation; counting resumes from 0 with a full prescale period.

Configuration
REQ-032 Macro COUNTER_PRESCALE_EN defined: the prescale port and a PRE_WIDTH-bit divider are present; the divider increments while enab=1 and load=0; tick=1 when divider == prescale, and that same edge returns the divider to 0.
REQ-033 With COUNTER_PRESCALE_EN defined: prescale = 0 yields tick every enabled cycle; load=1 or enab=0 clears the divider to 0.
REQ-034 Macro COUNTER_PRESCALE_EN undefined: no prescale port and no divider; tick = 1, one step per enabled cycle.

Verification (WIDTH=4, limit=9)
REQ-035 Reset, then up=1, sat=0, enab=1 for 12 cycles -> cnt_out 1..9,0,1,2; tc high one cycle with cnt_out=0; ovf=1 afterwards.
REQ-036 sat=1, up=0, load cnt_in=2, then enab 4 cycles -> cnt_out 1,0,0,0; tc high on the 2 held cycles; at_zero=1.
REQ-037 Load cnt_in=13, up=1, sat=0, step -> cnt_out=0, tc=1; repeat with sat=1 -> cnt_out=9.
REQ-038 Boundary step with clr_ovf=1 in the same cycle -> ovf=1; next cycle clr_ovf=1 with no boundary step -> ovf=0.
REQ-039 COUNTER_PRESCALE_EN defined, prescale=2, enab=1, up=1 -> cnt_out increments every 3rd cycle; rst pulse mid-period -> cnt_out=0 and the next increment comes 3 cycles after rst is released.

Source files
------------

// File: rtl/prog_counter.sv
// Loadable up/down counter with programmable limit, wrap/saturate boundary handling,
// terminal-count pulse and sticky overflow. Optional tick prescaler: COUNTER_PRESCALE_EN.
module prog_counter #(
   parameter int WIDTH     = 8,
   parameter int PRE_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 enab,
   input  logic                 up,
   input  logic                 sat,
   input  logic [WIDTH-1:0]     cnt_in,
   input  logic [WIDTH-1:0]     limit,
   input  logic                 clr_ovf,
`ifdef COUNTER_PRESCALE_EN
   input  logic [PRE_WIDTH-1:0] prescale,
`endif
   output logic [WIDTH-1:0]     cnt_out,
   output logic                 tc,
   output logic                 ovf,
   output logic                 at_zero
);

   logic             tick;
   logic             step;
   logic [WIDTH-1:0] cnt_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;

`ifdef COUNTER_PRESCALE_EN
   logic [PRE_WIDTH-1:0] div;

   assign tick = (div == prescale);

   // Divider only runs while steps are possible, so every enabled run starts a full period.
   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
      end else if (load || !enab) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end
`else
   localparam int unused_pre_width = PRE_WIDTH;

   assign tick = 1'b1;
`endif

   assign step = !load && enab && tick;

   always_comb begin
      cnt_nxt = cnt_out;
      tc_nxt  = 1'b0;
      ovf_nxt = ovf && !clr_ovf;
      if (load) begin
         cnt_nxt = cnt_in;
      end else if (step) begin
         if (up) begin
            // >= so a load above the limit still resolves on its first up step
            if (cnt_out < limit) begin
               cnt_nxt = cnt_out + 1'b1;
            end else begin
               cnt_nxt = sat ? limit : '0;
               tc_nxt  = 1'b1;
               ovf_nxt = 1'b1;
            end
         end else begin
            if (cnt_out != '0) begin
               cnt_nxt = cnt_out - 1'b1;
            end else begin
               cnt_nxt = sat ? '0 : limit;
               tc_nxt  = 1'b1;
               ovf_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_out <= '0;
         tc      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         cnt_out <= cnt_nxt;
         tc      <= tc_nxt;
         ovf     <= ovf_nxt;
      end
   end

   assign at_zero = (cnt_out == '0);

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter (WIDTH=4): the driver queues the expected post-edge
// outputs for each cycle, the monitor pops and compares one entry per clock.
module tb_prog_counter;

   localparam int W  = 4;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst, load, enab, up, sat, clr_ovf;
   logic [W-1:0]  cnt_in, limit;
   logic [PW-1:0] prescale;
   logic [W-1:0]  cnt_out;
   logic          tc, ovf, at_zero;

   typedef struct {
      logic [W-1:0] cnt;
      logic         tc;
      logic         ovf;
      string        tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   prog_counter #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .enab     (enab),
      .up       (up),
      .sat      (sat),
      .cnt_in   (cnt_in),
      .limit    (limit),
      .clr_ovf  (clr_ovf),
`ifdef COUNTER_PRESCALE_EN
      .prescale (prescale),
`endif
      .cnt_out  (cnt_out),
      .tc       (tc),
      .ovf      (ovf),
      .at_zero  (at_zero)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.tag, ".cnt"},     32'(cnt_out), 32'(e.cnt));
         check({e.tag, ".tc"},      32'(tc),      32'(e.tc));
         check({e.tag, ".ovf"},     32'(ovf),     32'(e.ovf));
         check({e.tag, ".at_zero"}, 32'(at_zero), 32'(e.cnt == '0));
      end
   end

   task automatic cyc(input string tag, input logic r, input logic ld, input logic en,
                      input logic u, input logic s, input logic [W-1:0] ci,
                      input logic [W-1:0] lim, input logic co,
                      input logic [W-1:0] e_cnt, input logic e_tc, input logic e_ovf);
      exp_t e;
      @(negedge clk);
      rst = r; load = ld; enab = en; up = u; sat = s;
      cnt_in = ci; limit = lim; clr_ovf = co;
      e.cnt = e_cnt; e.tc = e_tc; e.ovf = e_ovf; e.tag = tag;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; enab = 1'b0; up = 1'b1; sat = 1'b0;
      cnt_in = '0; limit = 4'd9; clr_ovf = 1'b0; prescale = '0;

      cyc("reset", 1, 1, 1, 1, 0, 4'd5, 4'd9, 0, 4'd0, 0, 0);

      // wrap up-count through the limit
      for (int i = 1; i <= 12; i++)
         cyc("wrap_up", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'(i % 10), i == 10, i >= 10);

      // saturating down-count held at zero
      cyc("sat_dn_load", 0, 1, 1, 0, 1, 4'd2, 4'd9, 0, 4'd2, 0, 1);
      cyc("sat_dn", 0, 0, 1, 0, 1, 4'd0, 4'd9, 0, 4'd1, 0, 1);
      cyc("sat_dn", 0, 0, 1, 0, 1, 4'd0, 4'd9, 0, 4'd0, 0, 1);
      cyc("sat_dn_hold", 0, 0, 1, 0, 1, 4'd0, 4'd9, 0, 4'd0, 1, 1);
      cyc("sat_dn_hold", 0, 0, 1, 0, 1, 4'd0, 4'd9, 0, 4'd0, 1, 1);

      // load above limit, then an up step resolves the boundary
      cyc("over_load_w", 0, 1, 1, 1, 0, 4'd13, 4'd9, 0, 4'd13, 0, 1);
      cyc("over_step_w", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd0, 1, 1);
      cyc("over_load_s", 0, 1, 1, 1, 1, 4'd13, 4'd9, 0, 4'd13, 0, 1);
      cyc("over_step_s", 0, 0, 1, 1, 1, 4'd0, 4'd9, 0, 4'd9, 1, 1);

      // ovf clear vs set in the same cycle
      cyc("clr_idle", 0, 0, 0, 1, 0, 4'd0, 4'd9, 1, 4'd9, 0, 0);
      cyc("clr_and_set", 0, 0, 1, 1, 0, 4'd0, 4'd9, 1, 4'd0, 1, 1);
      cyc("clr_only", 0, 0, 0, 1, 0, 4'd0, 4'd9, 1, 4'd0, 0, 0);

      // down wrap, normal down, hold
      cyc("dn_wrap", 0, 0, 1, 0, 0, 4'd0, 4'd9, 0, 4'd9, 1, 1);
      cyc("dn_step", 0, 0, 1, 0, 0, 4'd0, 4'd9, 0, 4'd8, 0, 1);
      cyc("hold", 0, 0, 0, 0, 0, 4'd3, 4'd9, 0, 4'd8, 0, 1);

      // limit change takes effect immediately
      cyc("lim_drop_sat", 0, 0, 1, 1, 1, 4'd0, 4'd5, 0, 4'd5, 1, 1);

      // limit zero: every step is a boundary
      cyc("lim0_up", 0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 4'd0, 1, 1);
      cyc("lim0_dn", 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 1);
      cyc("lim0_up_s", 0, 0, 1, 1, 1, 4'd0, 4'd0, 0, 4'd0, 1, 1);

      // priorities and mid-count reset
      cyc("load_pri", 0, 1, 1, 1, 0, 4'd7, 4'd9, 0, 4'd7, 0, 1);
      cyc("up_step", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd8, 0, 1);
      cyc("rst_mid", 1, 1, 1, 1, 0, 4'd4, 4'd9, 0, 4'd0, 0, 0);
      cyc("after_rst", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd1, 0, 0);

`ifdef COUNTER_PRESCALE_EN
      prescale = 4'd2;
      cyc("pre_rst", 1, 0, 0, 1, 0, 4'd0, 4'd9, 0, 4'd0, 0, 0);
      cyc("pre", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd0, 0, 0);
      cyc("pre", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd0, 0, 0);
      cyc("pre", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd1, 0, 0);
      cyc("pre", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd1, 0, 0);
      cyc("pre", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd1, 0, 0);
      cyc("pre", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd2, 0, 0);
      cyc("pre_mid", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd2, 0, 0);
      cyc("pre_rst_mid", 1, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd0, 0, 0);
      cyc("pre_resume", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd0, 0, 0);
      cyc("pre_resume", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd0, 0, 0);
      cyc("pre_resume", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd1, 0, 0);
`endif

      @(negedge clk);
      enab = 1'b0; load = 1'b0; rst = 1'b0; clr_ovf = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
